// File: rtl/clock_pkg.sv
// Shared encodings and field limits for the clock timekeeping core.
package clock_pkg;

  // Edit position; RUN means normal timekeeping, the others select a field.
  typedef enum logic [1:0] {
    EDIT_RUN  = 2'd0,
    EDIT_SEC  = 2'd1,
    EDIT_MIN  = 2'd2,
    EDIT_HOUR = 2'd3
  } edit_pos_e;

  // Terminal BCD values; each field wraps to 00 after reaching these.
  localparam logic [7:0] SEC_MAX  = 8'h59;
  localparam logic [7:0] MIN_MAX  = 8'h59;
  localparam logic [7:0] HOUR_MAX = 8'h23;

  // Edit position reached by one set_shift pulse.
  function automatic edit_pos_e next_edit_pos(input edit_pos_e pos);
    case (pos)
      EDIT_RUN:  return EDIT_SEC;
      EDIT_SEC:  return EDIT_MIN;
      EDIT_MIN:  return EDIT_HOUR;
      default:   return EDIT_RUN;
    endcase
  endfunction

endpackage

// File: rtl/bcd_mod_counter.sv
// Two-digit BCD counter that wraps to 00 after MAX.
// wrap is combinational so a carry chain settles within one cycle.
module bcd_mod_counter
  import clock_pkg::*;
#(
  parameter logic [7:0] MAX = SEC_MAX
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       inc,
  output logic [7:0] value,
  output logic       wrap
);

  logic [7:0] r_value;
  logic [7:0] w_next;

  // Next BCD value: wrap at MAX, otherwise carry units into tens at 9.
  always_comb begin
    // NOTE: a default assignment first keeps every path assigned, so no latch is inferred.
    w_next = r_value;
    if (r_value == MAX) begin
      w_next = 8'h00;
    end else if (r_value[3:0] == 4'd9) begin
      w_next = {r_value[7:4] + 4'd1, 4'd0};
    end else begin
      w_next = {r_value[7:4], r_value[3:0] + 4'd1};
    end
  end

  // Value register advances only when asked to.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    if (!rst_n) begin
      r_value <= 8'h00;
    end else if (inc) begin
      r_value <= w_next;
    end
  end

  assign value = r_value;
  assign wrap  = inc & (r_value == MAX);

endmodule

// File: rtl/clock_time_core.sv
// Timekeeping and time-setting core: 1 Hz prescaler, HH:MM:SS in BCD,
// and a set_shift / set_time edit mode that freezes counting while active.
module clock_time_core
  import clock_pkg::*;
#(
  parameter int CLK_DIV = 50_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       set_shift,
  input  logic       set_time,
  output logic [7:0] sec_bcd,
  output logic [7:0] min_bcd,
  output logic [7:0] hour_bcd,
  output logic [1:0] edit_pos,
  output logic       blink,
  output logic       tick_1hz
);

  localparam int PW = $clog2(CLK_DIV);

  logic [PW-1:0] r_presc;
  logic          r_tick;
  logic          r_blink;
  edit_pos_e     r_edit;
  edit_pos_e     w_edit_next;

  logic w_presc_wrap;
  logic w_run;
  logic w_set;
  logic w_sec_inc, w_min_inc, w_hour_inc;
  logic w_sec_wrap, w_min_wrap, w_hour_wrap;

  assign w_presc_wrap = (r_presc == PW'(CLK_DIV - 1));

  // Free-running prescaler; never paused or cleared by edit mode.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_presc <= '0;
    end else if (w_presc_wrap) begin
      r_presc <= '0;
    end else begin
      r_presc <= r_presc + PW'(1);
    end
  end

  // Registered 1 Hz tick and half-second blink, both one cycle behind the prescaler.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tick  <= 1'b0;
      r_blink <= 1'b0;
    end else begin
      r_tick  <= w_presc_wrap;
      r_blink <= (r_presc < PW'(CLK_DIV / 2));
    end
  end

  // Edit position state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_edit <= EDIT_RUN;
    end else begin
      r_edit <= w_edit_next;
    end
  end

  // Edit position next-state: one step per set_shift pulse.
  always_comb begin
    w_edit_next = r_edit;
    if (set_shift) begin
      w_edit_next = next_edit_pos(r_edit);
    end
  end

  // Counting happens only in RUN; set_shift takes priority over set_time.
  // A wrap while still in HOUR (including the edge leaving HOUR) is ignored.
  assign w_run = (r_edit == EDIT_RUN);
  assign w_set = set_time & ~set_shift;

  // Increment select: carry chain when running, single field when editing.
  assign w_sec_inc  = w_run ? w_presc_wrap : (w_set & (r_edit == EDIT_SEC));
  assign w_min_inc  = w_run ? w_sec_wrap   : (w_set & (r_edit == EDIT_MIN));
  assign w_hour_inc = w_run ? w_min_wrap   : (w_set & (r_edit == EDIT_HOUR));

  bcd_mod_counter #(.MAX(SEC_MAX)) u_sec (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (w_sec_inc),
    .value (sec_bcd),
    .wrap  (w_sec_wrap)
  );

  bcd_mod_counter #(.MAX(MIN_MAX)) u_min (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (w_min_inc),
    .value (min_bcd),
    .wrap  (w_min_wrap)
  );

  bcd_mod_counter #(.MAX(HOUR_MAX)) u_hour (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (w_hour_inc),
    .value (hour_bcd),
    .wrap  (w_hour_wrap)
  );

  assign edit_pos = r_edit;
  assign blink    = r_blink;
  assign tick_1hz = r_tick;

endmodule

// File: tb/tb_clock_time_core.sv
// Directed bench for clock_time_core with a queue of expected times
// popped on each tick_1hz pulse.
module tb_clock_time_core;

  localparam int CLK_DIV = 10;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       set_shift = 1'b0;
  logic       set_time = 1'b0;
  logic [7:0] sec_bcd, min_bcd, hour_bcd;
  logic [1:0] edit_pos;
  logic       blink, tick_1hz;

  clock_time_core #(.CLK_DIV(CLK_DIV)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .set_shift (set_shift),
    .set_time  (set_time),
    .sec_bcd   (sec_bcd),
    .min_bcd   (min_bcd),
    .hour_bcd  (hour_bcd),
    .edit_pos  (edit_pos),
    .blink     (blink),
    .tick_1hz  (tick_1hz)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  logic [23:0] sb_q[$];
  int m_h = 0, m_m = 0, m_s = 0;

  function automatic logic [7:0] to_bcd(input int v);
    return 8'(((v / 10) * 16) + (v % 10));
  endfunction

  function automatic logic [23:0] model_time();
    return {to_bcd(m_h), to_bcd(m_m), to_bcd(m_s)};
  endfunction

  function automatic logic [23:0] dut_time();
    return {hour_bcd, min_bcd, sec_bcd};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_tick();
    m_s++;
    if (m_s == 60) begin
      m_s = 0;
      m_m++;
      if (m_m == 60) begin
        m_m = 0;
        m_h = (m_h + 1) % 24;
      end
    end
  endtask

  // Drive inputs on the falling edge; captured at the following rising edge.
  task automatic step(input logic ss, input logic st);
    @(negedge clk);
    set_shift = ss;
    set_time  = st;
  endtask

  task automatic shifts(input int n);
    repeat (n) step(1'b1, 1'b0);
    step(1'b0, 1'b0);
  endtask

  task automatic times(input int n);
    repeat (n) step(1'b0, 1'b1);
    step(1'b0, 1'b0);
  endtask

  // Wait (bounded) for the next tick, then compare against the scoreboard head.
  task automatic wait_tick(input string tag);
    int n;
    logic [23:0] exp;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!tick_1hz && n < 2 * CLK_DIV);
    if (!tick_1hz) begin
      check({tag, "_tick_timeout"}, 32'(tick_1hz), 32'd1);
    end else begin
      exp = (sb_q.size() > 0) ? sb_q.pop_front() : 24'hxxxxxx;
      check({tag, "_time"}, 32'(dut_time()), 32'(exp));
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int last_k, ticks, highs;
    logic [23:0] exp;

    // Reset state while held in reset.
    #12;
    check("rst_time", 32'(dut_time()), 32'h0);
    check("rst_edit", 32'(edit_pos), 32'd0);
    check("rst_blink_tick", 32'({blink, tick_1hz}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Preload 12:34:56 through the edit path.
    shifts(1); times(56);
    shifts(1); times(34);
    shifts(1); times(12);
    check("preload_time", 32'(dut_time()), 32'h123456);
    check("preload_edit", 32'(edit_pos), 32'd3);

    // Asynchronous reset in mid-cycle, away from any rising edge.
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_time", 32'(dut_time()), 32'h0);
    check("async_rst_edit", 32'(edit_pos), 32'd0);
    check("async_rst_blink_tick", 32'({blink, tick_1hz}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    m_h = 0; m_m = 0; m_s = 0;

    // RUN for 600 cycles: 60 ticks every 10 cycles, blink 5 high / 5 low.
    for (int i = 0; i < 60; i++) begin
      model_tick();
      sb_q.push_back(model_time());
    end
    last_k = 0; ticks = 0; highs = 0;
    for (int k = 1; k <= 600; k++) begin
      @(negedge clk);
      if (blink) highs++;
      if (tick_1hz) begin
        ticks++;
        check("tick_spacing", 32'(k - last_k), 32'(CLK_DIV));
        last_k = k;
        exp = (sb_q.size() > 0) ? sb_q.pop_front() : 24'hxxxxxx;
        check("run_time", 32'(dut_time()), 32'(exp));
      end
    end
    check("run_tick_count", 32'(ticks), 32'd60);
    check("run_blink_high", 32'(highs), 32'd300);
    check("run_final_time", 32'(dut_time()), 32'h000100);
    check("run_sb_drained", 32'(sb_q.size()), 32'd0);

    // Rollover: set 23:59:59, return to RUN, next tick wraps to 00:00:00.
    shifts(1); times(59);
    shifts(1); times(58);
    shifts(1); times(23);
    check("set_max_time", 32'(dut_time()), 32'h235959);
    shifts(1);
    check("set_max_edit", 32'(edit_pos), 32'd0);
    check("set_max_held", 32'(dut_time()), 32'h235959);
    m_h = 23; m_m = 59; m_s = 59;
    model_tick();
    sb_q.push_back(model_time());
    wait_tick("rollover");
    repeat (CLK_DIV - 1) @(negedge clk);
    check("rollover_hold_time", 32'(dut_time()), 32'h000000);
    check("rollover_hold_tick", 32'(tick_1hz), 32'd0);
    model_tick();
    sb_q.push_back(model_time());
    wait_tick("after_rollover");

    // Seconds edit: 61 increments wrap once, no carry; time frozen in edit.
    shifts(1);
    check("sec_edit_pos", 32'(edit_pos), 32'd1);
    times(61);
    m_s = (m_s + 61) % 60;
    check("sec_edit_time", 32'(dut_time()), 32'(model_time()));
    ticks = 0;
    repeat (50) begin
      @(negedge clk);
      if (tick_1hz) ticks++;
    end
    check("frozen_time", 32'(dut_time()), 32'(model_time()));
    check("frozen_ticks", 32'(ticks), 32'd5);
    shifts(3);
    check("resume_edit", 32'(edit_pos), 32'd0);
    model_tick();
    sb_q.push_back(model_time());
    wait_tick("resume");

    // Hour edit: 25 increments wrap through 23->00, no carry elsewhere.
    shifts(3);
    check("hour_edit_pos", 32'(edit_pos), 32'd3);
    times(25);
    m_h = (m_h + 25) % 24;
    check("hour_edit_time", 32'(dut_time()), 32'(model_time()));
    shifts(1);
    model_tick();
    sb_q.push_back(model_time());
    wait_tick("after_hour_edit");

    // Collision: set_shift and set_time together in SEC -> MIN, sec unchanged.
    shifts(1);
    check("coll_pre_edit", 32'(edit_pos), 32'd1);
    step(1'b1, 1'b1);
    step(1'b0, 1'b0);
    check("coll_edit", 32'(edit_pos), 32'd2);
    check("coll_time", 32'(dut_time()), 32'(model_time()));
    shifts(2);
    check("coll_back_run", 32'(edit_pos), 32'd0);
    model_tick();
    sb_q.push_back(model_time());
    wait_tick("after_collision");

    // set_time in RUN is ignored.
    times(1);
    check("run_set_time_ignored", 32'(dut_time()), 32'(model_time()));
    check("run_set_time_edit", 32'(edit_pos), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/clock_time_core.md
Name: clock_time_core

Overview:
- Timekeeping and time-setting core of the digital clock. Sits directly downstream of the key edge-pulse stage and consumes its one-cycle set_shift / set_time pulses.
- Holds hours:minutes:seconds as BCD and advances them once per second from a clock prescaler.
- Provides an edit mode: set_shift selects a field, set_time increments that field.
- Outputs drive the display/scan stage.

Parameters:
- CLK_DIV, 50_000_000, clk cycles per second; legal range >= 4, even.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- set_shift  in  1  one-cycle pulse; advance edit position
- set_time  in  1  one-cycle pulse; increment selected field
- sec_bcd  out  8  seconds, BCD {tens,units}, 00..59
- min_bcd  out  8  minutes, BCD, 00..59
- hour_bcd  out  8  hours, BCD, 00..23
- edit_pos  out  2  0=RUN, 1=SEC, 2=MIN, 3=HOUR
- blink  out  1  high during first half of each second; display blanks the selected field when low
- tick_1hz  out  1  one-cycle pulse at each prescaler wrap

Behaviour:
- Reset and clocking: one clock, clk. Reset is asynchronous and active-low (rst_n). On reset, all outputs are 0: time 00:00:00, edit_pos=RUN, blink=0, tick_1hz=0, prescaler=0.
- Prescaler:
  - Counts 0..CLK_DIV-1 and wraps. Runs continuously in all modes.
  - tick_1hz is registered; it is 1 in the cycle after the prescaler equals CLK_DIV-1.
  - blink is registered; blink = (prescaler < CLK_DIV/2), so it updates one cycle after the prescaler.
- Edit FSM (edit_pos):
  - Transitions on set_shift: RUN->SEC->MIN->HOUR->RUN. It moves one step per pulse.
  - set_shift pulses on consecutive cycles each advance one step.
- RUN mode: on each tick, time advances by one second.
  - sec 59->00 carries to min.
  - min 59->00 (with carry) carries to hour.
  - hour 23->00 wraps, with no further carry.
  - Updates take effect on the same edge that raises tick_1hz; time outputs change with 1-cycle latency from the internal wrap.
- Edit modes (SEC/MIN/HOUR):
  - Timekeeping is frozen: ticks are ignored. The prescaler and blink still run.
  - set_time increments only the selected field, modulo 60/60/24, with no carry into other fields.
  - Examples: sec 59->00 leaves min unchanged; hour 23->00.
- Simultaneous events:
  - set_shift and set_time in the same cycle: set_shift wins and set_time is dropped.
  - set_time in RUN is ignored.
  - A tick coinciding with set_shift that leaves HOUR->RUN is not applied. Counting resumes from the next tick.
- Returning to RUN does not reset the prescaler.
- Entering edit mode does not modify time.
- BCD rules:
  - Units nibble counts 0..9; tens nibble increments when units wrap.
  - Field wrap compares the full byte against 8'h59 / 8'h23.
  - Illegal BCD codes are unreachable. No detection is required.
- Reset mid-edit: the asynchronous return to RUN at 00:00:00 takes effect immediately.

Decomposition:
- Shared package clock_pkg:
  - edit-position encodings EDIT_RUN/EDIT_SEC/EDIT_MIN/EDIT_HOUR (2-bit)
  - constants SEC_MAX=8'h59, MIN_MAX=8'h59, HOUR_MAX=8'h23
- One sub-module, bcd_mod_counter:
  - Parameter MAX (BCD byte).
  - Inputs: clk, rst_n, inc.
  - Outputs: value[7:0], and combinational wrap = inc & (value==MAX).
  - Instantiated three times.
- Each instance's inc is driven by the core's mux of tick-carry vs set_time select.

Test Plan (CLK_DIV=10):
- Reset 12:34:56 preloaded via edits, then assert rst_n=0 mid-cycle -> all outputs 0 asynchronously, edit_pos=0.
- RUN from 00:00:00 for 600 cycles -> 60 tick_1hz pulses spaced 10 cycles, time 00:01:00. blink pattern is 5 high / 5 low.
- Rollover: set 23:59:59, return to RUN, next tick -> 00:00:00; no further change until the following tick.
- Edit sequence: set_shift x1 -> edit_pos=1; set_time x61 -> sec=01, min/hour unchanged. Run 50 cycles -> time frozen. set_shift x3 -> edit_pos=0 and counting resumes.
- Hour edit: set_shift x3, set_time x25 -> hour=01, sec/min unchanged, no carry.
- Collision: edit_pos=SEC, set_shift and set_time in the same cycle -> edit_pos=MIN, sec unchanged. A set_time pulse in RUN -> no change.
